// File: rtl/alu8_arbiter.sv
// alu8_arbiter
// Shares one combinational alu8 datapath between two requesters.
// Each requester hands over (A, B, sel, cin) on a valid/ready handshake.
// Requests are granted round-robin and the operands are registered. The ALU
// is driven from those registers for one cycle, and the result comes back on
// a valid/ready response channel tagged with the requester ID.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid[1:0]             per-requester request valid (index = ID)
//   req_ready[1:0]             per-requester accept (one-hot or zero)
//   reqN_a/_b/_sel/_cin        requester N operands, opcode, carry-in
//   alu_a/_b/_sel/_cin         registered operands to the external ALU
//   alu_y, alu_c               ALU result and carry
//   resp_valid/_ready          response handshake
//   resp_id/_y/_c/_err         response fields (held until accepted)
//   busy                       FSM not idle
//   op_count                   completed responses, wraps
module alu8_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic [3:0]       req0_sel,
  input  logic             req0_cin,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic [3:0]       req1_sel,
  input  logic             req1_cin,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_cin,
  input  logic [7:0]       alu_y,
  input  logic             alu_c,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [7:0]       resp_y,
  output logic             resp_c,
  output logic             resp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [3:0]       sel_q, sel_d;
  logic             cin_q, cin_d;
  logic             id_q, id_d;
  logic [7:0]       resp_y_q, resp_y_d;
  logic             resp_c_q, resp_c_d;
  logic             resp_err_q, resp_err_d;
  logic             resp_id_q, resp_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Request ports gathered into arrays so the selected requester can be indexed.
  logic [7:0] req_a   [2];
  logic [7:0] req_b   [2];
  logic [3:0] req_sel [2];
  logic       req_cin [2];

  assign req_a[0]   = req0_a;
  assign req_b[0]   = req0_b;
  assign req_sel[0] = req0_sel;
  assign req_cin[0] = req0_cin;
  assign req_a[1]   = req1_a;
  assign req_b[1]   = req1_b;
  assign req_sel[1] = req1_sel;
  assign req_cin[1] = req1_cin;

  logic any_valid;
  logic gnt_id;

  assign any_valid = |req_valid;
  // Contention goes to prio. Otherwise the single valid requester wins.
  assign gnt_id    = (&req_valid) ? prio_q : req_valid[1];

  // Ready is only ever raised toward a valid requester. So in IDLE, any_valid
  // is exactly the handshake condition for the granted requester.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_q == IDLE) && req_valid[gi] && (gnt_id == 1'(gi));
    end
  endgenerate

  logic illegal_op;
  logic arith_op;

  assign illegal_op = (sel_q > OP_LAST);
  assign arith_op   = (sel_q == OP_ADD) || (sel_q == OP_SUB);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    cin_d      = cin_q;
    id_d       = id_q;
    resp_y_d   = resp_y_q;
    resp_c_d   = resp_c_q;
    resp_err_d = resp_err_q;
    resp_id_d  = resp_id_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          a_d     = req_a[gnt_id];
          b_d     = req_b[gnt_id];
          sel_d   = req_sel[gnt_id];
          cin_d   = req_cin[gnt_id];
          id_d    = gnt_id;
          prio_d  = ~gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        resp_id_d = id_q;
        if (illegal_op) begin
          resp_y_d   = 8'h00;
          resp_c_d   = 1'b0;
          resp_err_d = 1'b1;
        end else begin
          resp_y_d   = alu_y;
          // The ALU leaves C stale for logic ops, so it is masked.
          resp_c_d   = arith_op ? alu_c : 1'b0;
          resp_err_d = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      cin_q      <= 1'b0;
      id_q       <= 1'b0;
      resp_y_q   <= '0;
      resp_c_q   <= 1'b0;
      resp_err_q <= 1'b0;
      resp_id_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      cin_q      <= cin_d;
      id_q       <= id_d;
      resp_y_q   <= resp_y_d;
      resp_c_q   <= resp_c_d;
      resp_err_q <= resp_err_d;
      resp_id_q  <= resp_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;
  assign alu_cin    = cin_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_y     = resp_y_q;
  assign resp_c     = resp_c_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu8_arbiter.sv
// Testbench for alu8_arbiter. The bench provides a behavioural alu8 model.
// Accepted requests push their expected response into a scoreboard queue.
// A negedge monitor checks arbitration, the ALU drive, latency, stability
// and the response fields.
module tb_alu8_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic          v0, v1;
  logic [7:0]    a0, b0, a1, b1;
  logic [3:0]    sel0, sel1;
  logic          cin0, cin1;
  logic [7:0]    alu_a, alu_b, alu_y;
  logic [3:0]    alu_sel;
  logic          alu_cin, alu_c;
  logic          resp_valid, resp_ready, resp_id, resp_c, resp_err, busy;
  logic [7:0]    resp_y;
  logic [CW-1:0] op_count;
  logic          rr_mode, rr_main, rr_rand;

  assign req_valid  = {v1, v0};
  assign resp_ready = rr_mode ? rr_rand : rr_main;

  always #5 clk = ~clk;

  alu8_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(a0), .req0_b(b0), .req0_sel(sel0), .req0_cin(cin0),
    .req1_a(a1), .req1_b(b1), .req1_sel(sel1), .req1_cin(cin1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_c(alu_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_y(resp_y), .resp_c(resp_c), .resp_err(resp_err),
    .busy(busy), .op_count(op_count)
  );

  // alu8 model. C is deliberately left at 1 for non-arithmetic ops (stale carry).
  // Y is 0x5A for illegal opcodes, so the arbiter has to mask both.
  always_comb begin
    alu_c = 1'b1;
    alu_y = 8'h5A;
    case (alu_sel)
      4'd0: {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      4'd1: {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      4'd2: alu_y = alu_a & alu_b;
      4'd3: alu_y = alu_a | alu_b;
      4'd4: alu_y = ~(alu_a & alu_b);
      4'd5: alu_y = ~(alu_a | alu_b);
      4'd6: alu_y = ~alu_a;
      4'd7: alu_y = alu_a ^ alu_b;
      4'd8: alu_y = ~(alu_a ^ alu_b);
      default: ;
    endcase
  end

  typedef struct {
    logic       id;
    logic [7:0] a, b, y;
    logic [3:0] sel;
    logic       cin, c, err;
    int         cyc;
  } exp_t;

  exp_t     sb[$];
  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  logic     model_prio;
  logic [CW-1:0] model_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result computed from the opcode rules with plain integer arithmetic.
  function automatic exp_t ref_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] sel, input logic cin);
    exp_t e;
    int   s;
    e.id = id; e.a = a; e.b = b; e.sel = sel; e.cin = cin;
    e.c = 1'b0; e.err = 1'b0; e.y = 8'h00; e.cyc = 0;
    case (sel)
      4'd0: begin s = int'(a) + int'(b) + int'(cin); e.y = 8'(s % 256); e.c = (s > 255); end
      4'd1: begin s = int'(a) - int'(b); e.y = 8'((s + 256) % 256); e.c = (a >= b); end
      4'd2: e.y = a & b;
      4'd3: e.y = a | b;
      4'd4: e.y = ~(a & b);
      4'd5: e.y = ~(a | b);
      4'd6: e.y = ~a;
      4'd7: e.y = a ^ b;
      4'd8: e.y = ~(a ^ b);
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor / scoreboard
  initial begin
    exp_t       e, cur;
    logic       in_resp = 1'b0;
    logic       alu_chk = 1'b0;
    int         alu_cyc = 0;
    logic       pick;
    logic [11:0] snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        in_resp    = 1'b0;
        alu_chk    = 1'b0;
        model_prio = 1'b0;
        model_cnt  = '0;
      end else begin
        chk("op_count", op_count, model_cnt);
        if (alu_chk && cyc == alu_cyc) begin
          e = sb[sb.size()-1];
          chk("alu_drive", {alu_a, alu_b, alu_sel, alu_cin}, {e.a, e.b, e.sel, e.cin});
          chk("busy_exec", busy, 1);
          alu_chk = 1'b0;
        end
        if (req_ready != 2'b00) begin
          chk("ready_onehot", $countones(req_ready), 1);
          pick = (req_valid == 2'b11) ? model_prio : req_valid[1];
          chk("grant", req_ready, pick ? 2'b10 : 2'b01);
          chk("busy_idle", busy, 0);
          if ((req_ready & req_valid) != 2'b00) begin
            if (req_ready[1]) e = ref_op(1'b1, a1, b1, sel1, cin1);
            else              e = ref_op(1'b0, a0, b0, sel0, cin0);
            e.cyc = cyc;
            sb.push_back(e);
            model_prio = ~req_ready[1];
            alu_chk    = 1'b1;
            alu_cyc    = cyc + 1;
          end
        end
        if (resp_valid) begin
          chk("ready_in_resp", req_ready, 0);
          chk("busy_resp", busy, 1);
          if (!in_resp) begin
            if (sb.size() == 0) begin
              chk("unexpected_resp", resp_valid, 0);
            end else begin
              cur = sb[0];
              chk("resp_latency", cyc, cur.cyc + 2);
              chk("resp_y", resp_y, cur.y);
              chk("resp_c", resp_c, cur.c);
              chk("resp_err", resp_err, cur.err);
              chk("resp_id", resp_id, cur.id);
              snap    = {resp_id, resp_y, resp_c, resp_err, 1'b1};
              in_resp = 1'b1;
            end
          end else begin
            chk("resp_stable", {resp_id, resp_y, resp_c, resp_err, 1'b1}, snap);
          end
          if (in_resp && resp_ready) begin
            cur = sb.pop_front();
            $display("resp id=%0d sel=%0d a=%02h b=%02h cin=%0d -> y=%02h c=%0d err=%0d count=%0d",
                     resp_id, cur.sel, cur.a, cur.b, cur.cin, resp_y, resp_c, resp_err, op_count);
            model_cnt = model_cnt + 1'b1;
            in_resp   = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic cin);
    int n = 0;
    if (id == 0) begin a0 = a; b0 = b; sel0 = sel; cin0 = cin; v0 = 1'b1; end
    else         begin a1 = a; b1 = b; sel1 = sel; cin1 = cin; v1 = 1'b1; end
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[id] && n < 200);
    chk("accept_timeout", req_ready[id], 1);
    @(posedge clk);
    #1;
    if (id == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || resp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp", {resp_id, resp_y, resp_c, resp_err}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_sel, alu_cin}, 0);
    chk("rst_op_count", op_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Background random response backpressure, used only when rr_mode is set.
  initial begin
    rr_rand = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rr_rand = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0;
    a0 = '0; b0 = '0; sel0 = '0; cin0 = 1'b0;
    a1 = '0; b1 = '0; sel1 = '0; cin1 = 1'b0;
    rr_mode = 1'b0; rr_main = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed operations
    issue(0, 8'hF0, 8'h20, 4'd0, 1'b0); wait_drain();
    issue(1, 8'h05, 8'h07, 4'd1, 1'b0); wait_drain();
    issue(1, 8'h07, 8'h05, 4'd1, 1'b0); wait_drain();
    issue(0, 8'hFF, 8'h01, 4'd0, 1'b1); wait_drain();
    issue(0, 8'hCC, 8'hAA, 4'd2, 1'b0); wait_drain();
    issue(0, 8'h12, 8'h34, 4'hC, 1'b1); wait_drain();

    // Contention: both held valid for two operations each
    fork
      begin issue(0, 8'h11, 8'h22, 4'd3, 1'b0); issue(0, 8'h80, 8'h80, 4'd0, 1'b0); end
      begin issue(1, 8'h0F, 8'hF0, 4'd7, 1'b0); issue(1, 8'h00, 8'h01, 4'd1, 1'b0); end
    join
    wait_drain();

    // Request dropped within the grant cycle: no handshake, prio unchanged
    v0 = 1'b1;
    #1 chk("drop_ready", req_ready, 2'b01);
    #1 v0 = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_busy", busy, 0);

    // Backpressure for 5 cycles while requester 1 waits
    rr_main = 1'b0;
    issue(0, 8'h3C, 8'h0F, 4'd8, 1'b0);
    fork
      issue(1, 8'hA5, 8'h5A, 4'd5, 1'b0);
      begin
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        chk("bp_resp_timeout", resp_valid, 1);
        repeat (5) begin
          @(negedge clk);
          chk("bp_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 rr_main = 1'b1;
      end
    join
    wait_drain();

    // Reset during EXEC, then contention must go to requester 0
    issue(1, 8'h01, 8'h02, 4'd0, 1'b0);
    chk("in_exec", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_vals();
    repeat (4) @(negedge clk);
    chk("no_resp_after_rst", resp_valid, 0);
    @(posedge clk);
    #1;
    fork
      issue(0, 8'h44, 8'h33, 4'd1, 1'b0);
      issue(1, 8'h44, 8'h33, 4'd0, 1'b0);
      begin @(negedge clk); chk("grant_after_rst", req_ready, 2'b01); end
    join
    wait_drain();

    // Randomized traffic with random backpressure; enough to wrap op_count
    rr_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic d0, d1;
      d0 = $urandom_range(0, 1);
      d1 = $urandom_range(0, 1);
      if (!d0 && !d1) d0 = 1'b1;
      fork
        if (d0) issue(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
        if (d1) issue(1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
      join
    end
    rr_mode = 1'b0;
    wait_drain();
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
